branch_ras_unit: RTL
====================

// Module: branch_ras_unit
// PURPOSE
//  Registered branch-resolution stage with a parametrised return-address stack (RAS).
//  Evaluates the condition code against the flag register and computes the target (relative/absolute).
//  Supports call (link) and return, with valid/ready handshakes on both sides.
//  Sits between decode/execute and the fetch redirect logic.
// PARAMETERS
//  ADDR_W     32  width of pc/src/target
//  FLAG_W     6   flag register width, must be >= 6
//  RAS_DEPTH  8   RAS entries, power of 2, >= 2
//  PC_INC     4   link address = pc_i + PC_INC
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       asynchronous reset, active-high
//  valid_i        in   1       request valid
//  ready_o        out  1       request accepted when valid_i && ready_o
//  pc_i           in   ADDR_W  pc of the branch
//  cc_i           in   4       [2:0] condition select, [3] invert
//  flags_i        in   FLAG_W  flag register
//  src_i          in   ADDR_W  rs value (offset or absolute target)
//  abs_i          in   1       1 = absolute, 0 = pc-relative
//  link_i         in   1       call: push link address if taken
//  ret_i          in   1       return: target from RAS top if taken
//  flush_i        in   1       kill output register and same-cycle request
//  clr_err_i      in   1       clear sticky error bits
//  valid_o        out  1       result valid
//  ready_i        in   1       consumer ready
//  dest_addr_o    out  ADDR_W  resolved target
//  branch_en_o    out  1       branch taken
//  ras_empty_o    out  1       RAS count == 0
//  ras_full_o     out  1       RAS count == RAS_DEPTH
//  ras_ovf_o      out  1       sticky: push while full
//  ras_unf_o      out  1       sticky: taken return while empty
// BEHAVIOUR
//  Reset: valid_o=0, dest_addr_o=0, branch_en_o=0, RAS ptr/count=0, ras_empty_o=1, ras_full_o=0, ovf/unf=0.
//  Handshake:
//   - ready_o = !valid_o || ready_i (combinational).
//   - Output holds stable while valid_o && !ready_i.
//   - Latency 1 cycle: accept at edge N, result is visible after edge N.
//  Condition, cond = cc_i[2:0]:
//   - 000 -> 1; k in 001..101 -> flags_i[FLAG_W-k]; 110/111 -> 0.
//   - taken = cond ^ cc_i[3], so 1000 is "never" and 1110 is "always".
//  Target:
//   - abs_i ? src_i : pc_i+src_i, modulo 2^ADDR_W.
//   - Taken ret_i with RAS non-empty: target = RAS top, ignoring src_i/abs_i.
//  Not-taken: dest_addr_o = computed target anyway, branch_en_o = 0, RAS untouched.
//  RAS updates only on an accepted, taken, non-flushed request:
//   - link only: push pc_i+PC_INC. When full, overwrite the oldest entry (circular), count stays RAS_DEPTH, set ovf.
//   - ret only: pop. When empty, count stays 0, target uses the src/abs rule, set unf.
//   - link && ret: replace top with the link address, count unchanged; target = old top (empty: src/abs rule, set unf, then push).
//  flush_i:
//   - Next cycle valid_o = 0.
//   - A same-cycle request is dropped with no RAS update.
//   - RAS contents are kept.
//  clr_err_i clears ovf/unf. A same-cycle set event wins.
//  Reset mid-operation: everything returns to reset values asynchronously. Pending results are lost.
// TESTING
//  1. cc=0001, flags=6'b100000, abs=0, pc=0x100, src=0x20 -> next cycle valid_o=1, branch_en_o=1, dest=0x120.
//  2. cc=1001 with the same flags -> branch_en_o=0, dest=0x120; cc=0110 -> 0; cc=1110 -> 1.
//  3. call pc=0x40 (link, cc=0000), then ret (cc=0000) -> dest=0x44, ras_empty_o=1 again.
//  4. 9 calls with RAS_DEPTH=8 -> ras_full_o=1, ras_ovf_o=1; 8 rets return the newest 8 link addresses in LIFO order.
//  5. ret on empty RAS, abs=1, src=0x800 -> dest=0x800, ras_unf_o=1; clr_err_i -> 0.
//  6. ready_i=0 for 3 cycles: ready_o=0, outputs stable; flush_i -> valid_o=0 and the RAS is unchanged.

Source files
------------

// File: rtl/branch_ras_unit.sv
// branch_ras_unit
//   A registered branch-resolution stage with a circular return-address stack.
//   It checks the condition code against the flags and works out the target,
//   which is either absolute or pc-relative. Calls push a link address onto
//   the stack and returns pop one. Both sides use a valid/ready handshake and
//   the result appears one cycle after a request is accepted.
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   valid_i / ready_o             request handshake
//   pc_i, cc_i, flags_i, src_i    branch pc, condition code, flags, offset/target
//   abs_i, link_i, ret_i          absolute target, call, return
//   flush_i                       kill output register and same-cycle request
//   clr_err_i                     clear sticky ovf/unf
//   valid_o / ready_i             result handshake
//   dest_addr_o, branch_en_o      resolved target, taken
//   ras_empty_o, ras_full_o       stack occupancy
//   ras_ovf_o, ras_unf_o          sticky overflow / underflow
module branch_ras_unit #(
  parameter int ADDR_W    = 32,
  parameter int FLAG_W    = 6,
  parameter int RAS_DEPTH = 8,
  parameter int PC_INC    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [3:0]        cc_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic              abs_i,
  input  logic              link_i,
  input  logic              ret_i,
  input  logic              flush_i,
  input  logic              clr_err_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] dest_addr_o,
  output logic              branch_en_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_ovf_o,
  output logic              ras_unf_o
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;   // next push slot; when full this is the oldest entry
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  ras_cnt;

  logic              cond, taken, accept, upd;
  logic [ADDR_W-1:0] link_addr, calc_tgt, target;

  // flags_i[0] is never selected when FLAG_W == 6
  logic unused_flags;
  assign unused_flags = ^flags_i[FLAG_W-6:0];

  always_comb begin
    cond = 1'b0;
    case (cc_i[2:0])
      3'd0:    cond = 1'b1;
      3'd1:    cond = flags_i[FLAG_W-1];
      3'd2:    cond = flags_i[FLAG_W-2];
      3'd3:    cond = flags_i[FLAG_W-3];
      3'd4:    cond = flags_i[FLAG_W-4];
      3'd5:    cond = flags_i[FLAG_W-5];
      default: cond = 1'b0;
    endcase
  end

  assign taken       = cond ^ cc_i[3];
  assign ready_o     = !valid_o || ready_i;
  assign accept      = valid_i && ready_o && !flush_i;
  assign upd         = accept && taken;
  assign ras_empty_o = (ras_cnt == '0);
  assign ras_full_o  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign top_ptr     = wr_ptr - PTR_W'(1);
  assign link_addr   = pc_i + ADDR_W'(PC_INC);
  assign calc_tgt    = abs_i ? src_i : pc_i + src_i;
  // A taken return reads the stack top. When the stack is empty it falls back to src/abs.
  assign target      = (ret_i && taken && !ras_empty_o) ? ras_mem[top_ptr] : calc_tgt;

  // Stack storage. An entry is only read while ras_cnt covers it, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (upd && link_i) begin
      if (ret_i && !ras_empty_o) ras_mem[top_ptr] <= link_addr;  // replace top
      else                       ras_mem[wr_ptr]  <= link_addr;  // push (wraps over oldest)
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      ras_cnt     <= '0;
      ras_ovf_o   <= 1'b0;
      ras_unf_o   <= 1'b0;
      valid_o     <= 1'b0;
      dest_addr_o <= '0;
      branch_en_o <= 1'b0;
    end else begin
      if (upd) begin
        if (link_i && !ret_i) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (!ras_full_o) ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (!link_i && ret_i) begin
          if (!ras_empty_o) begin
            wr_ptr  <= top_ptr;
            ras_cnt <= ras_cnt - CNT_W'(1);
          end
        end else if (link_i && ret_i && ras_empty_o) begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          ras_cnt <= ras_cnt + CNT_W'(1);
        end
      end

      // A set event in the same cycle takes priority over the clear.
      if (upd && link_i && !ret_i && ras_full_o) ras_ovf_o <= 1'b1;
      else if (clr_err_i)                         ras_ovf_o <= 1'b0;
      if (upd && ret_i && ras_empty_o)            ras_unf_o <= 1'b1;
      else if (clr_err_i)                         ras_unf_o <= 1'b0;

      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (accept) begin
        valid_o     <= 1'b1;
        dest_addr_o <= target;
        branch_en_o <= taken;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule
